uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a valid/ready byte output and one-cycle error pulses.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx #(
   parameter int clock_freq = 50000000,
   parameter int baud       = 115200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int DIV   = clock_freq / baud;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK
   } state_t;
`endif

   state_t           r_state;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_sync3;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [7:0]       r_shift;
   logic [7:0]       r_data;
   logic             r_valid;
   logic             r_frame_err;
   logic             r_overrun_err;
   logic             r_busy;

   logic             w_line;
   logic             w_fall;
   logic             w_mid;
   logic             w_handshake;
   logic             w_par_ok;
   logic             w_complete;

`ifdef UART_RX_PARITY_EN
   logic             r_par_err;
   logic             r_par_bad;
   assign w_par_ok = ~r_par_bad;
`else
   assign w_par_ok = 1'b1;
`endif

   assign w_line      = r_sync2;
   assign w_fall      = r_sync3 & ~r_sync2;
   assign w_mid       = (r_cnt == CNT_LAST);
   assign w_handshake = r_valid & data_ready;
   // A byte is complete only on a good stop sample of a frame whose parity (if any) matched.
   assign w_complete  = (r_state == ST_STOP) && w_mid && w_line && w_par_ok;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_sync3       <= 1'b1;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_shift       <= '0;
         r_data        <= '0;
         r_valid       <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
         r_busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_err     <= 1'b0;
         r_par_bad     <= 1'b0;
`endif
      end else begin
         r_sync1       <= rxd;
         r_sync2       <= r_sync1;
         r_sync3       <= r_sync2;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_err     <= 1'b0;
`endif

         // A handshake on the completing edge frees the slot for the new byte.
         if (w_complete) begin
            if (!r_valid || w_handshake) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun_err <= 1'b1;
            end
         end else if (w_handshake) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_fall) begin
                  r_state <= ST_START;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  r_par_bad <= 1'b0;
`endif
               end
            end

            ST_START: begin
               if (r_cnt == CNT_HALF) begin
                  r_cnt <= '0;
                  if (!w_line) begin
                     r_state <= ST_DATA;
                     r_idx   <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               if (w_mid) begin
                  r_cnt   <= '0;
                  r_shift <= {w_line, r_shift[7:1]};
                  r_idx   <= r_idx + 1'b1;
                  if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (w_mid) begin
                  r_cnt   <= '0;
                  r_state <= ST_STOP;
                  if ((^r_shift) != w_line) begin
                     r_par_bad <= 1'b1;
                     r_par_err <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif

            ST_STOP: begin
               if (w_mid) begin
                  r_cnt <= '0;
                  if (w_line) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // Line held low past the stop bit: wait for it to recover before hunting for a start.
            ST_BREAK: begin
               if (w_line) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data        = r_data;
   assign data_valid  = r_valid;
   assign frame_err   = r_frame_err;
   assign overrun_err = r_overrun_err;
   assign busy        = r_busy;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = r_par_err;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a cycle-level event model of the receiver outputs.
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

   localparam int CLK_F = 50000000;
   localparam int BAUD  = 115200;
   localparam int DIV   = CLK_F / BAUD;
   localparam int HALF  = DIV / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 10;
`else
   localparam int NBITS = 9;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       rxd = 1'b1;
   logic       data_ready = 1'b0;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       overrun_err;
   logic       parity_err;
   logic       busy;

   uart_rx #(.clock_freq(CLK_F), .baud(BAUD)) dut (
      .clock       (clock),
      .reset       (reset),
      .rxd         (rxd),
      .data        (data),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .parity_err  (parity_err),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   // One entry per line event: k = first edge the start level is present,
   // c = edge of the stop-bit mid-sample, bend = first edge after which busy is 0.
   typedef struct {
      int         k;
      int         c;
      int         bend;
      bit         glitch;
      bit         stop_ok;
      bit         par_bad;
      logic [7:0] b;
   } ev_t;

   ev_t        evq[$];
   int         cyc = 0;
   logic       rdy_q = 1'b0;
   logic       rst_q = 1'b0;
   int         n_chk = 0;
   int         n_err = 0;
   int         n_fe = 0;
   int         n_oe = 0;
   int         n_pe = 0;
   logic [7:0] m_data = 8'h00;
   logic       m_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clock) begin
      cyc++;
      rdy_q = data_ready;
      rst_q = reset;
   end

   always @(negedge clock) begin
      bit         m_fe, m_oe, m_pe, m_busy, load, hs;
      logic [7:0] ld;
      ev_t        keep[$];
      m_fe = 0; m_oe = 0; m_pe = 0; m_busy = 0; load = 0; ld = 8'h00;
      if (rst_q !== 1'b1) begin
         m_data  = 8'h00;
         m_valid = 1'b0;
         evq.delete();
      end else begin
         hs = m_valid && (rdy_q === 1'b1);
         keep = {};
         foreach (evq[i]) begin
            if (!evq[i].glitch) begin
               if (evq[i].par_bad && cyc == evq[i].c - DIV) m_pe = 1;
               if (cyc == evq[i].c) begin
                  if (!evq[i].stop_ok) m_fe = 1;
                  else if (!evq[i].par_bad) begin
                     load = 1;
                     ld   = evq[i].b;
                  end
               end
            end
            if (cyc >= evq[i].k + 2 && cyc < evq[i].bend) m_busy = 1;
            if (cyc < evq[i].bend || cyc < evq[i].c) keep.push_back(evq[i]);
         end
         evq = keep;
         if (load) begin
            if (!m_valid || hs) begin
               m_data  = ld;
               m_valid = 1'b1;
            end else begin
               m_oe = 1;
            end
         end else if (hs) begin
            m_valid = 1'b0;
         end
      end
      chk("data", {24'd0, data}, {24'd0, m_data});
      chk("data_valid", {31'd0, data_valid}, {31'd0, m_valid});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
      chk("overrun_err", {31'd0, overrun_err}, {31'd0, m_oe});
      chk("parity_err", {31'd0, parity_err}, {31'd0, m_pe});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      if (frame_err === 1'b1) n_fe++;
      if (overrun_err === 1'b1) n_oe++;
      if (parity_err === 1'b1) n_pe++;
   end

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low,
                             input bit par_bad);
      ev_t e;
      @(negedge clock);
      e.k       = cyc + 1;
      e.c       = e.k + 2 + HALF + NBITS * DIV;
      e.glitch  = 1'b0;
      e.stop_ok = stop_ok;
      e.par_bad = par_bad;
      e.b       = b;
      e.bend    = stop_ok ? e.c : e.k + (NBITS + 1) * DIV + extra_low + 2;
      evq.push_back(e);
      rxd = 1'b0;
      repeat (DIV) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (DIV) @(negedge clock);
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^b) ^ par_bad;
      repeat (DIV) @(negedge clock);
`endif
      rxd = stop_ok;
      repeat (DIV + (stop_ok ? 0 : extra_low)) @(negedge clock);
      rxd = 1'b1;
      repeat (30) @(negedge clock);
   endtask

   task automatic send_glitch(input int len);
      ev_t e;
      @(negedge clock);
      e.k       = cyc + 1;
      e.c       = -1;
      e.glitch  = 1'b1;
      e.stop_ok = 1'b1;
      e.par_bad = 1'b0;
      e.b       = 8'h00;
      e.bend    = e.k + 2 + HALF;
      evq.push_back(e);
      rxd = 1'b0;
      repeat (len) @(negedge clock);
      rxd = 1'b1;
      repeat (400) @(negedge clock);
   endtask

   task automatic consume();
      @(negedge clock);
      data_ready = 1'b1;
      @(negedge clock);
      data_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int fe0, oe0, pe0;
      repeat (5) @(negedge clock);
      chk("reset data", {24'd0, data}, 32'h00);
      chk("reset valid", {31'd0, data_valid}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      repeat (20) @(negedge clock);

      send_frame(8'hA5, 1'b1, 0, 1'b0);
      chk("A5 data", {24'd0, data}, 32'hA5);
      chk("A5 valid", {31'd0, data_valid}, 32'd1);
      consume();
      chk("A5 valid after ready", {31'd0, data_valid}, 32'd0);
      chk("A5 data held", {24'd0, data}, 32'hA5);

      oe0 = n_oe;
      send_frame(8'h3C, 1'b1, 0, 1'b0);
      send_frame(8'hC3, 1'b1, 0, 1'b0);
      chk("overrun data kept", {24'd0, data}, 32'h3C);
      chk("overrun pulses", n_oe - oe0, 32'd1);
      consume();

      fe0 = n_fe;
      send_frame(8'h55, 1'b0, 5000, 1'b0);
      chk("break frame pulses", n_fe - fe0, 32'd1);
      chk("break no valid", {31'd0, data_valid}, 32'd0);
      send_frame(8'h12, 1'b1, 0, 1'b0);
      chk("after break data", {24'd0, data}, 32'h12);
      chk("after break valid", {31'd0, data_valid}, 32'd1);
      consume();

      fe0 = n_fe; oe0 = n_oe;
      send_glitch(100);
      chk("glitch no valid", {31'd0, data_valid}, 32'd0);
      chk("glitch idle", {31'd0, busy}, 32'd0);
      chk("glitch no errors", (n_fe - fe0) + (n_oe - oe0), 32'd0);

      fork
         send_frame(8'hFF, 1'b1, 0, 1'b0);
         begin
            repeat (5 * DIV + HALF) @(negedge clock);
            reset = 1'b0;
            repeat (4) @(negedge clock);
            chk("midframe reset data", {24'd0, data}, 32'h00);
            chk("midframe reset busy", {31'd0, busy}, 32'd0);
            reset = 1'b1;
         end
      join
      send_frame(8'h01, 1'b1, 0, 1'b0);
      chk("after reset data", {24'd0, data}, 32'h01);
      chk("after reset valid", {31'd0, data_valid}, 32'd1);
      consume();

`ifdef UART_RX_PARITY_EN
      pe0 = n_pe;
      send_frame(8'h07, 1'b1, 0, 1'b1);
      chk("parity bad pulses", n_pe - pe0, 32'd1);
      chk("parity bad no valid", {31'd0, data_valid}, 32'd0);
      send_frame(8'h07, 1'b1, 0, 1'b0);
      chk("parity good data", {24'd0, data}, 32'h07);
      chk("parity good valid", {31'd0, data_valid}, 32'd1);
      consume();
`else
      pe0 = n_pe;
      chk("parity never pulses", pe0, 32'd0);
`endif

      repeat (10) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
